// File: rtl/full.sv
// full: parameterizable ripple-carry full adder with a load-enabled registered result
module full #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             load,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] Sum_q,
  output logic             Carry_q,
  output logic             valid_q
);
  logic [WIDTH:0] c;
  assign G = A & B;
  assign P = A ^ B;
  assign c[0] = Cin;
  assign Carry = c[WIDTH];
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign Sum[i] = P[i] ^ c[i];
    assign c[i+1] = G[i] | (c[i] & P[i]);
  end
  // capture the combinational result on load; reset clears the copy immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Sum_q   <= '0;
      Carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (load) begin
      Sum_q   <= Sum;
      Carry_q <= Carry;
      valid_q <= 1'b1;
    end
endmodule

// File: tb/tb_full.sv
// tb_full: self-checking bench for full at WIDTH=1 and WIDTH=8
module tb_full;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, ld1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic c8 = 1'b0, ld8 = 1'b0;
  logic s1, co1, g1, p1, sq1, cq1, v1;
  logic [7:0] s8, g8, p8, sq8;
  logic co8, cq8, v8;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  full #(.WIDTH(1)) d1 (.clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .load(ld1),
    .Sum(s1), .Carry(co1), .G(g1), .P(p1), .Sum_q(sq1), .Carry_q(cq1), .valid_q(v1));
  full #(.WIDTH(8)) d8 (.clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .load(ld8),
    .Sum(s8), .Carry(co8), .G(g8), .P(p8), .Sum_q(sq8), .Carry_q(cq8), .valid_q(v8));

  wire [1:0] m1 = 2'(a1) + 2'(b1) + 2'(c1);
  wire [8:0] m8 = 9'(a8) + 9'(b8) + 9'(c8);

  logic e_sq1, e_cq1, e_v1, e_cq8, e_v8;
  logic [7:0] e_sq8;

  always @(posedge clk or posedge rst)
    if (rst) begin
      e_sq1 <= 1'b0; e_cq1 <= 1'b0; e_v1 <= 1'b0;
      e_sq8 <= '0;   e_cq8 <= 1'b0; e_v8 <= 1'b0;
    end else begin
      if (ld1) begin e_sq1 <= m1[0]; e_cq1 <= m1[1]; e_v1 <= 1'b1; end
      if (ld8) begin e_sq8 <= m8[7:0]; e_cq8 <= m8[8]; e_v8 <= 1'b1; end
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cs1", {62'd0, co1, s1}, {62'd0, m1});
    chk("gp1", {62'd0, g1, p1}, {62'd0, a1 & b1, a1 ^ b1});
    chk("reg1", {61'd0, v1, cq1, sq1}, {61'd0, e_v1, e_cq1, e_sq1});
    chk("cs8", {55'd0, co8, s8}, {55'd0, m8});
    chk("gp8", {48'd0, g8, p8}, {48'd0, a8 & b8, a8 ^ b8});
    chk("reg8", {54'd0, v8, cq8, sq8}, {54'd0, e_v8, e_cq8, e_sq8});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_state1", {61'd0, v1, cq1, sq1}, 64'd0);
    chk("rst_state8", {54'd0, v8, cq8, sq8}, 64'd0);
    ld1 = 1'b1; ld8 = 1'b1;
    step();
    chk("rst_ignores_load", {61'd0, v1, cq1, sq1}, 64'd0);
    rst = 1'b0; ld1 = 1'b0; ld8 = 1'b0;
    step();
    chk("post_rst_hold", {61'd0, v1, cq1, sq1}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      {a1, b1, c1} = 3'(i);
      #1 chk($sformatf("tt%0d", i), {62'd0, co1, s1}, {62'd0, tt[i]});
    end
    step();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    #1 chk("gp_11", {62'd0, g1, p1}, 64'b10);
    a1 = 1'b1; b1 = 1'b0;
    #1 chk("gp_10", {62'd0, g1, p1}, 64'b01);
    step();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; ld1 = 1'b1;
    step();
    ld1 = 1'b0; a1 = 1'b0; c1 = 1'b1;
    #1 chk("cap_vsq", {61'd0, v1, cq1, sq1}, 64'b110);
    step();
    chk("cap_hold", {61'd0, v1, cq1, sq1}, 64'b110);
    rst = 1'b1;
    #1 chk("async_rst1", {61'd0, v1, cq1, sq1}, 64'd0);
    a1 = 1'b1;
    #1 chk("comb_in_rst", {62'd0, co1, s1}, 64'b11);
    step();
    rst = 1'b0;
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    #1 chk("wrap_ff", {55'd0, co8, s8}, {55'd0, 9'h100});
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    #1 chk("wrap_7f", {55'd0, co8, s8}, {55'd0, 9'h080});
    ld8 = 1'b1;
    step();
    ld8 = 1'b0;
    #1 chk("cap8", {54'd0, v8, cq8, sq8}, {54'd0, 10'h280});
    for (int i = 0; i < 1000; i++) begin
      step();
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      ld8 = 1'($urandom); ld1 = 1'($urandom);
      {a1, b1, c1} = 3'($urandom);
    end
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
